// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: op encodings, FSM states,
// and a small helper that tells signed ops apart from unsigned ones.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    // DIV and REM treat operands as two's complement; DIVU/REMU do not.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/seq_divider_rca.sv
// Ripple-carry adder/subtractor. With sub_en=1 it computes a - b and cout
// is the no-borrow flag (1 when a >= b as unsigned).
module RCA #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub_en,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_x;

    assign carry[0] = sub_en;
    assign b_x      = b ^ {WIDTH{sub_en}};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b_x[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; signs are applied in FIN.
// Optional build macro SEQ_DIVIDER_EARLY_OUT_EN: skip the iterations when
// |a| < |b| (loses constant-time behaviour).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t             state_reg, state_next;
    logic               rem_sel_reg;
    logic               sign_a_reg, sign_b_reg;
    logic [WIDTH-1:0]   dvd_reg;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_reg;     // divisor magnitude
    logic [WIDTH-1:0]   rem_reg;     // partial remainder
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               done_reg;

    logic               accept;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               no_borrow;
    logic               trial_msb_unused;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               b_zero;
    logic               early;

    // A start coinciding with the done pulse is dropped so back-to-back
    // requests always see a clean IDLE cycle first.
    assign accept = (state_reg == S_IDLE) && start && !done_reg;

    assign sign_a = a[WIDTH-1] & is_signed_op(op);
    assign sign_b = b[WIDTH-1] & is_signed_op(op);
    assign a_mag  = sign_a ? (~a) + WIDTH'(1) : a;
    assign b_mag  = sign_b ? (~b) + WIDTH'(1) : b;
    assign b_zero = (b == '0);

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Trial subtract: {rem, next dividend bit} - {0, divisor}.
    assign shifted = {rem_reg, dvd_reg[WIDTH-1]};

    RCA #(.WIDTH(WIDTH + 1)) u_trial (
        .a      (shifted),
        .b      ({1'b0, dvs_reg}),
        .sub_en (1'b1),
        .sum    (trial),
        .cout   (no_borrow)
    );

    // On a successful subtract the top bit is always zero, so only the low
    // WIDTH bits ever feed back into the remainder.
    assign trial_msb_unused = trial[WIDTH];

    assign quo_fix = (sign_a_reg ^ sign_b_reg) ? (~dvd_reg) + WIDTH'(1) : dvd_reg;
    assign rem_fix = sign_a_reg ? (~rem_reg) + WIDTH'(1) : rem_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (b_zero || early) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (count_reg == CNT_W'(1)) begin
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring step per RUN cycle, sign fix-up in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_sel_reg <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            count_reg   <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        rem_sel_reg <= op[1];
                        count_reg   <= CNT_W'(WIDTH);
                        dvs_reg     <= b_mag;
                        if (b_zero) begin
                            // Quotient all ones, remainder is the raw dividend:
                            // clear the sign flags so FIN passes both through.
                            sign_a_reg <= 1'b0;
                            sign_b_reg <= 1'b0;
                            dvd_reg    <= '1;
                            rem_reg    <= a;
                        end else if (early) begin
                            sign_a_reg <= sign_a;
                            sign_b_reg <= sign_b;
                            dvd_reg    <= '0;
                            rem_reg    <= a_mag;
                        end else begin
                            sign_a_reg <= sign_a;
                            sign_b_reg <= sign_b;
                            dvd_reg    <= a_mag;
                            rem_reg    <= '0;
                        end
                    end
                end
                S_RUN: begin
                    rem_reg   <= no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dvd_reg   <= {dvd_reg[WIDTH-2:0], no_borrow};
                    count_reg <= count_reg - CNT_W'(1);
                end
                S_FIN: begin
                    result_reg <= rem_sel_reg ? rem_fix : quo_fix;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of ops with hand-computed
// results and latencies, a random sweep against a reference model, and
// hand-written sequences for ignored starts and mid-operation reset.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        string        name;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] xm, ym;
        xm = (!o[0] && x[W-1]) ? -x : x;
        ym = (!o[0] && y[W-1]) ? -y : y;
        if (y == '0) return 1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        if (xm < ym) return 1;
`endif
        if (xm == ym) return W + 1;
        return W + 1;
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] q, r;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (!o[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
        end else begin
            q = x / y;
            r = x % y;
        end
        return o[1] ? r : q;
    endfunction

    // Issue one op from a clean IDLE cycle; return result and done latency (0 = timeout).
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] res, output int lat);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                res = result;
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] res;
        int           lat;
        int           ndone;
        int           first;
        logic         busy_mid;
        logic         busy34;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        vq.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         "divu_100_7"});
        vq.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2,          "remu_100_7"});
        vq.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2"});
        vq.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"});
        vq.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"});
        vq.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  "rem_ovf"});
        vq.push_back('{OP_DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  "divu_by0"});
        vq.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  "rem_m5_by0"});
        vq.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  "div_m5_by0"});
        vq.push_back('{OP_REMU, 32'h0000_1234,  32'd0,          32'h0000_1234,  "remu_by0"});
        vq.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  "div_7_m2"});
        vq.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          "rem_7_m2"});
        vq.push_back('{OP_DIVU, 32'd3,          32'd9,          32'd0,          "divu_3_9"});
        vq.push_back('{OP_REMU, 32'd3,          32'd9,          32'd3,          "remu_3_9"});
        vq.push_back('{OP_DIV,  32'd0,          32'd5,          32'd0,          "div_0_5"});
        vq.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "divu_max_1"});
        vq.push_back('{OP_DIV,  32'd20,         32'hFFFF_FFFF,  32'hFFFF_FFEC,  "div_20_m1"});
        vq.push_back('{OP_REM,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  "rem_m20_3"});

        // Reset state
        #2;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vq[i]) begin
            do_op(vq[i].op, vq[i].a, vq[i].b, res, lat);
            $display("[TB] %s op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d",
                     vq[i].name, vq[i].op, vq[i].a, vq[i].b, res, lat);
            check({vq[i].name, "_result"}, res, vq[i].res);
            check({vq[i].name, "_lat"}, lat, exp_lat(vq[i].op, vq[i].a, vq[i].b));
        end

        // Restarts during busy and in the done cycle are ignored
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; first = 0; res = '0; busy_mid = 1'b0; busy34 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = n;
                    res = result;
                end
            end
            if (n == 5) busy_mid = busy;
            if (n == 4 || n == 31) begin
                start = 1'b1; a = 32'd50; b = 32'd5;
            end
            if (n == 5 || n == 32) start = 1'b0;
            if (n == 33) start = 1'b1;
            if (n == 34) begin
                start = 1'b0;
                busy34 = busy;
            end
        end
        $display("[TB] restart_ignored dones=%0d first=%0d result=0x%08h busy34=%0b", ndone, first, res, busy34);
        check("restart_dones",  ndone, 32'd1);
        check("restart_first",  first, 32'd33);
        check("restart_result", res,   32'd14);
        check("restart_busy",   {31'd0, busy_mid}, 32'd1);
        check("done_cycle_start_ignored", {31'd0, busy34}, 32'd0);

        // Reset in the middle of an operation
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_busy",   {31'd0, busy}, 32'd0);
        check("midreset_done",   {31'd0, done}, 32'd0);
        check("midreset_result", result,        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        $display("[TB] midreset dones_after=%0d result=0x%08h", ndone, result);
        check("midreset_no_done", ndone, 32'd0);

        // Random sweep against the reference model
        for (int i = 0; i < 250; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = '0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'($urandom_range(0, 1000));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = '0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(1, 50));
                4:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, res, lat);
            $display("[TB] rand%0d op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d", i, ro, ra, rb, res, lat);
            check("rand_result", res, ref_div(ro, ra, rb));
            check("rand_lat", lat, exp_lat(ro, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
